// File: rtl/hour_chime_seq.sv
// Hourly chime sequencer: at the top of the hour, beeps Di N times (N = hour, 12/24h) with programmable on/off times.
// Optional build macro QUARTER_CHIME_EN adds 1/2/3-beep chimes at hh:15:00, hh:30:00 and hh:45:00.
module hour_chime_seq #(
  parameter int HOUR_MODE  = 12,
  parameter int BEEP_ON    = 500,
  parameter int BEEP_OFF   = 500,
  parameter int MAX_CHIMES = 24
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic [7:0] Hour,
  input  logic [7:0] Minute,
  input  logic [7:0] Second,
  input  logic       tell,
  output logic       Di,
  output logic       busy,
  output logic [4:0] remain
);

  localparam int TMAX = (BEEP_ON > BEEP_OFF) ? BEEP_ON : BEEP_OFF;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] ON_LAST  = TW'(BEEP_ON - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(BEEP_OFF - 1);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  state_t        state;
  logic [TW-1:0] timer;

  // BCD hour to beep count; malformed digits or hours past 23 give 0 (no chime)
  function automatic int hour_to_chimes(input logic [7:0] h);
    int tens;
    int ones;
    int bin;
    tens = int'(h[7:4]);
    ones = int'(h[3:0]);
    bin  = tens * 10 + ones;
    if (tens > 9 || ones > 9 || bin > 23) return 0;
    if (HOUR_MODE == 24) return (bin == 0) ? 24 : bin;
    return (bin == 0) ? 12 : ((bin > 12) ? bin - 12 : bin);
  endfunction

  function automatic logic [4:0] clamp_chimes(input int n);
    if (n > MAX_CHIMES) return 5'(MAX_CHIMES);
    return 5'(n);
  endfunction

  function automatic logic [TW-1:0] timer_inc(input logic [TW-1:0] t);
    return (t == '1) ? t : t + 1'b1;
  endfunction

  // Stage p0: combinational time-of-day match
  logic match_top_p0;
  logic match_top_p1;
  logic rise_top;
  logic trig;
  logic [4:0] trig_n;

  assign match_top_p0 = (Minute == 8'h00) && (Second == 8'h00);
  assign rise_top     = match_top_p0 & ~match_top_p1;

`ifdef QUARTER_CHIME_EN
  logic [2:0] match_qtr_p0;
  logic [2:0] match_qtr_p1;
  logic [2:0] rise_qtr;

  assign match_qtr_p0 = {Minute == 8'h45, Minute == 8'h30, Minute == 8'h15} & {3{Second == 8'h00}};
  assign rise_qtr     = match_qtr_p0 & ~match_qtr_p1;
`endif

  always_comb begin
    trig   = rise_top;
    trig_n = clamp_chimes(hour_to_chimes(Hour));
`ifdef QUARTER_CHIME_EN
    if (rise_qtr != 3'b000) begin
      trig   = 1'b1;
      trig_n = clamp_chimes(rise_qtr[0] ? 1 : (rise_qtr[1] ? 2 : 3));
    end
`endif
    trig = trig & tell & (state == IDLE);
  end

  // Stage p1: registered match history; reset to "already matched" so leaving reset at 00:00 stays silent
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      match_top_p1 <= 1'b1;
`ifdef QUARTER_CHIME_EN
      match_qtr_p1 <= 3'b111;
`endif
    end else begin
      match_top_p1 <= match_top_p0;
`ifdef QUARTER_CHIME_EN
      match_qtr_p1 <= match_qtr_p0;
`endif
    end
  end

  // Stage p1: beep sequencer with registered buzzer/status outputs
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state  <= IDLE;
      Di     <= 1'b0;
      busy   <= 1'b0;
      remain <= 5'd0;
      timer  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (trig && trig_n != 5'd0) begin
            state  <= ON;
            Di     <= 1'b1;
            busy   <= 1'b1;
            remain <= trig_n;
            timer  <= '0;
          end
        end
        ON: begin
          if (!tell) begin
            state  <= IDLE;
            Di     <= 1'b0;
            busy   <= 1'b0;
            remain <= 5'd0;
            timer  <= '0;
          end else if (timer == ON_LAST) begin
            timer <= '0;
            Di    <= 1'b0;
            if (remain > 5'd1) begin
              state  <= OFF;
              remain <= remain - 5'd1;
            end else begin
              // last beep ends the sequence directly, no trailing gap
              state  <= IDLE;
              busy   <= 1'b0;
              remain <= 5'd0;
            end
          end else begin
            timer <= timer_inc(timer);
          end
        end
        OFF: begin
          if (!tell) begin
            state  <= IDLE;
            Di     <= 1'b0;
            busy   <= 1'b0;
            remain <= 5'd0;
            timer  <= '0;
          end else if (timer == OFF_LAST) begin
            state <= ON;
            Di    <= 1'b1;
            timer <= '0;
          end else begin
            timer <= timer_inc(timer);
          end
        end
        default: begin
          state  <= IDLE;
          Di     <= 1'b0;
          busy   <= 1'b0;
          remain <= 5'd0;
          timer  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hour_chime_seq.sv
// Scoreboard bench for hour_chime_seq: three instances (12h, 24h, 24h clamped to 6) share stimulus.
module tb_hour_chime_seq;

  localparam int NI   = 3;
  localparam int BON  = 4;
  localparam int BOFF = 3;

  logic       CP     = 1'b0;
  logic       nCR    = 1'b1;
  logic [7:0] Hour   = 8'h03;
  logic [7:0] Minute = 8'h59;
  logic [7:0] Second = 8'h59;
  logic       tell   = 1'b1;

  logic       di_w   [NI];
  logic       busy_w [NI];
  logic [4:0] rem_w  [NI];

  typedef struct {
    int n;
    bit abort;
    int issue;
  } exp_t;

  exp_t exp_q [NI][$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always #5 CP = ~CP;
  always @(posedge CP) cyc <= cyc + 1;

  function automatic int mode_of(int i);
    return (i == 0) ? 12 : 24;
  endfunction

  function automatic int max_of(int i);
    return (i == 2) ? 6 : 24;
  endfunction

  // Reference beep count straight from the hour-convention rules
  function automatic int model_n(int i, logic [7:0] h);
    int tens;
    int ones;
    int b;
    int n;
    tens = int'(h[7:4]);
    ones = int'(h[3:0]);
    if (tens > 9 || ones > 9) return 0;
    b = tens * 10 + ones;
    if (b > 23) return 0;
    if (mode_of(i) == 12) n = (b == 0) ? 12 : ((b > 12) ? b - 12 : b);
    else                  n = (b == 0) ? 24 : b;
    return (n > max_of(i)) ? max_of(i) : n;
  endfunction

  task automatic check(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit any_busy();
    return busy_w[0] | busy_w[1] | busy_w[2];
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    hour_chime_seq #(
      .HOUR_MODE ((g == 0) ? 12 : 24),
      .BEEP_ON   (BON),
      .BEEP_OFF  (BOFF),
      .MAX_CHIMES((g == 2) ? 6 : 24)
    ) u_dut (
      .CP    (CP),
      .nCR   (nCR),
      .Hour  (Hour),
      .Minute(Minute),
      .Second(Second),
      .tell  (tell),
      .Di    (di_w[g]),
      .busy  (busy_w[g]),
      .remain(rem_w[g])
    );

    bit   in_seq    = 1'b0;
    bit   prev_di   = 1'b0;
    bit   prev_tell = 1'b1;
    int   pulses    = 0;
    int   hi_len    = 0;
    int   lo_len    = 0;
    int   busy_len  = 0;
    exp_t cur;

    // Sequence monitor: measures each busy window and compares against the popped expectation
    always @(posedge CP) begin
      #1;
      if (prev_tell && !tell) begin
        check($sformatf("tell_drop_busy[%0d]", g), busy_w[g], 0);
        check($sformatf("tell_drop_di[%0d]", g), di_w[g], 0);
      end
      if (busy_w[g] && !in_seq) begin
        in_seq   = 1'b1;
        pulses   = 0;
        hi_len   = 0;
        lo_len   = 0;
        busy_len = 0;
        if (exp_q[g].size() == 0) begin
          check($sformatf("unexpected_chime[%0d]", g), 1, 0);
          cur.n     = 0;
          cur.abort = 1'b1;
          cur.issue = cyc;
        end else begin
          cur = exp_q[g].pop_front();
          check($sformatf("start_latency_ok[%0d]", g),
                int'((cyc - cur.issue) >= 1 && (cyc - cur.issue) <= 2), 1);
        end
      end
      if (in_seq) begin
        if (busy_w[g]) begin
          busy_len++;
          if (di_w[g]) begin
            if (!prev_di) begin
              pulses++;
              if (!cur.abort) begin
                if (pulses > 1) check($sformatf("off_gap[%0d]", g), lo_len, BOFF);
                check($sformatf("remain_at_beep[%0d]", g), int'(rem_w[g]), cur.n - pulses + 1);
              end
              hi_len = 0;
            end
            hi_len++;
          end else begin
            if (prev_di) begin
              if (!cur.abort) check($sformatf("on_width[%0d]", g), hi_len, BON);
              lo_len = 0;
            end
            lo_len++;
          end
        end else begin
          if (!cur.abort) begin
            check($sformatf("last_on_width[%0d]", g), hi_len, BON);
            check($sformatf("busy_len[%0d]", g), busy_len, cur.n * BON + (cur.n - 1) * BOFF);
            check($sformatf("end_remain[%0d]", g), int'(rem_w[g]), 0);
          end
          check($sformatf("pulse_count[%0d]", g), pulses, cur.n);
          check($sformatf("end_di[%0d]", g), di_w[g], 0);
          in_seq = 1'b0;
        end
      end
      prev_di   = di_w[g];
      prev_tell = tell;
    end

    // Asynchronous clear must be visible before any clock edge
    always @(negedge nCR) begin
      #1;
      check($sformatf("reset_di[%0d]", g), di_w[g], 0);
      check($sformatf("reset_busy[%0d]", g), busy_w[g], 0);
      check($sformatf("reset_remain[%0d]", g), int'(rem_w[g]), 0);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic push_hour(logic [7:0] h, bit abort, int k);
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e.n     = abort ? k : model_n(i, h);
      e.abort = abort;
      e.issue = cyc;
      if (model_n(i, h) > 0 && tell) exp_q[i].push_back(e);
    end
  endtask

  task automatic push_count(int q);
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      e.n     = (q > max_of(i)) ? max_of(i) : q;
      e.abort = 1'b0;
      e.issue = cyc;
      if (q > 0 && tell) exp_q[i].push_back(e);
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 400;
    tick(3);
    while (budget > 0 && any_busy()) begin
      tick(1);
      budget--;
    end
    check("idle_timeout", int'(any_busy()), 0);
  endtask

  task automatic leave_match();
    Minute = 8'h00;
    Second = 8'h01;
    tick(2);
    tell = 1'b1;
  endtask

  task automatic hour_chime(logic [7:0] h, bit t);
    Hour   = h;
    tell   = t;
    Minute = 8'h59;
    Second = 8'h59;
    tick(2);
    push_hour(h, 1'b0, 0);
    Minute = 8'h00;
    Second = 8'h00;
    tick(3);
    Hour = 8'($urandom_range(0, 35));
    wait_idle();
    leave_match();
  endtask

  task automatic quarter_chime(logic [7:0] mm, int q);
    Minute = mm - 8'h01;
    if (mm == 8'h30) Minute = 8'h29;
    Second = 8'h59;
    tick(2);
`ifdef QUARTER_CHIME_EN
    push_count(q);
`else
    push_count(0 * q);
`endif
    Minute = mm;
    Second = 8'h00;
    wait_idle();
    leave_match();
  endtask

  initial begin
    bit last;
    int rises;
    int budget;

    #2 nCR = 1'b0;
    tick(2);
    nCR = 1'b1;
    tick(2);

    hour_chime(8'h03, 1'b1);
    hour_chime(8'h00, 1'b1);
    hour_chime(8'h15, 1'b1);
    hour_chime(8'h20, 1'b1);
    hour_chime(8'h09, 1'b1);

    // tell dropped just after the second beep starts
    Hour = 8'h05; tell = 1'b1; Minute = 8'h59; Second = 8'h59;
    tick(2);
    push_hour(8'h05, 1'b1, 2);
    Minute = 8'h00; Second = 8'h00;
    rises = 0; last = 1'b0; budget = 200;
    while (rises < 2 && budget > 0) begin
      tick(1);
      if (di_w[0] && !last) rises++;
      last = di_w[0];
      budget--;
    end
    check("abort_second_beep_seen", rises, 2);
    tell = 1'b0;
    tick(5);
    tell = 1'b1;
    tick(5);
    wait_idle();
    leave_match();

    hour_chime(8'h07, 1'b0);

    // reset pulsed during the first gap, then released while still at 00:00
    Hour = 8'h03; tell = 1'b1; Minute = 8'h59; Second = 8'h59;
    tick(2);
    push_hour(8'h03, 1'b1, 1);
    Minute = 8'h00; Second = 8'h00;
    last = 1'b0; budget = 100;
    while (!(last && !di_w[0]) && budget > 0) begin
      last = di_w[0];
      tick(1);
      budget--;
    end
    check("reset_gap_reached", budget > 0, 1);
    tick(1);
    nCR = 1'b0;
    tick(3);
    nCR = 1'b1;
    tick(20);
    wait_idle();
    leave_match();

    hour_chime(8'h2A, 1'b1);
    hour_chime(8'h24, 1'b1);
    hour_chime(8'hA1, 1'b1);

    // 00:00 held for 100 cycles must chime once
    Hour = 8'h02; tell = 1'b1; Minute = 8'h59; Second = 8'h59;
    tick(2);
    push_hour(8'h02, 1'b0, 0);
    Minute = 8'h00; Second = 8'h00;
    tick(100);
    wait_idle();
    leave_match();

    quarter_chime(8'h15, 1);
    quarter_chime(8'h30, 2);
    quarter_chime(8'h45, 3);

    repeat (10) hour_chime(8'($urandom_range(0, 47)), $urandom_range(0, 3) != 0);

    for (int i = 0; i < NI; i++) check($sformatf("leftover_expected[%0d]", i), exp_q[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
